// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t  - fetch FSM states
//   HLT_OPCODE_DEF - default opcode value that stops fetching
//   OPCODE_W       - opcode field width; the field occupies the top OPCODE_W
//                    bits of an instruction word
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int unsigned OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] HLT_OPCODE_DEF = 4'hF;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO holding prefetched instructions.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write an entry (ignored when full or flushing)
//   pop, dout   read the head entry; dout is the current head (show-ahead)
//   flush       empty the FIFO; wins over a same-cycle push/pop
//   full, empty, count  occupancy status
// DEPTH must be a power of two so that the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with variable-latency memory handshake
// and a prefetch queue feeding IF/ID.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req, imem_addr            fetch request and its address (= fetch PC)
//   imem_ack                       memory accepts the request this cycle
//   imem_rvalid, imem_rdata        one response per accepted request
//   redirect, redirect_pc          flush and restart fetch at a new PC
//   id_ready                       IF/ID can accept the head instruction
//   instr_valid, instr             head of the queue (instr = 0 when invalid)
//   instr_pc_plus2                 head PC + 2 (0 when invalid)
//   pc_out                         current fetch PC
//   fetch_halted                   fetch stopped by a HLT instruction
// Build option: define FETCH_BYPASS_EN to forward a response straight to
// IF/ID when the queue is empty and ID is ready (zero-cycle latency).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         DATA_W     = 16,
  parameter int unsigned         ADDR_W     = 16,
  parameter int unsigned         DEPTH      = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
  parameter logic [OPCODE_W-1:0] HLT_OPCODE = HLT_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc_plus2,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_halted
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc_plus2;
  } q_entry_t;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_req_pc;
  logic [ADDR_W-1:0] w_req_pc_nxt;
  logic              r_started;

  logic              w_q_full;
  logic              w_q_empty;
  logic [CNT_W-1:0]  w_q_count;
  q_entry_t          w_q_din;
  q_entry_t          w_q_dout;
  logic              w_push;
  logic              w_pop;
  logic              w_resp;
  logic              w_bypass;
  logic              w_is_hlt;
  logic [ADDR_W-1:0] w_resp_pc_plus2;

  // r_started keeps imem_req low while reset is asserted.
  assign imem_req = r_started & (r_state == FETCH) & (w_q_count < CNT_W'(DEPTH)) & ~redirect;
  assign imem_addr    = r_fetch_pc;
  assign pc_out       = r_fetch_pc;
  assign fetch_halted = (r_state == HALTED);

  assign w_is_hlt        = (imem_rdata[DATA_W-1 -: OPCODE_W] == HLT_OPCODE);
  assign w_resp          = (r_state == WAIT) & imem_rvalid & ~redirect;
  assign w_resp_pc_plus2 = r_req_pc + ADDR_W'(2);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_resp & w_q_empty & id_ready;
`else
  assign w_bypass = 1'b0;
`endif

  // The reserved-slot request rule means full is never hit on push.
  assign w_push           = w_resp & ~w_bypass & ~w_q_full;
  assign w_pop            = ~w_q_empty & id_ready;
  assign w_q_din.instr    = imem_rdata;
  assign w_q_din.pc_plus2 = w_resp_pc_plus2;

  assign instr_valid    = ~w_q_empty | w_bypass;
  assign instr          = ~w_q_empty ? w_q_dout.instr :
                          (w_bypass ? imem_rdata : '0);
  assign instr_pc_plus2 = ~w_q_empty ? w_q_dout.pc_plus2 :
                          (w_bypass ? w_resp_pc_plus2 : '0);

  fetch_fifo #(
    .WIDTH ($bits(q_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   (w_q_din),
    .full  (w_q_full),
    .empty (w_q_empty),
    .count (w_q_count),
    .dout  (w_q_dout)
  );

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_started  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_started  <= 1'b1;
    end
  end

  // Next-state and PC update; redirect overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    if (redirect) begin
      w_fetch_pc_nxt = redirect_pc;
      case (r_state)
        WAIT:    w_state_nxt = imem_rvalid ? FETCH : DRAIN;
        // A response landing in the same cycle retires the outstanding request.
        DRAIN:   w_state_nxt = imem_rvalid ? FETCH : DRAIN;
        default: w_state_nxt = FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            w_req_pc_nxt   = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(2);
            w_state_nxt    = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            w_state_nxt = w_is_hlt ? HALTED : FETCH;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a randomised
// variable-latency memory and a program-order reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc_plus2;
  logic [15:0] pc_out;
  logic        fetch_halted;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc_plus2 (instr_pc_plus2),
    .pc_out         (pc_out),
    .fetch_halted   (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instruction memory image, word-indexed by addr[15:1].
  logic [15:0] mem [0:32767];

  // Reference model: program order of deliveries and requests.
  logic [15:0] m_pc;
  logic [15:0] m_req_pc;
  bit          m_stop;
  bit          m_done;
  int          n_deliv;
  int          n_acc;

  // Memory responder state (one outstanding request).
  bit          pend_v;
  int          pend_cnt;
  logic [15:0] pend_addr;
  int          ack_pct;
  int          lat_min;
  int          lat_max;

  // Observations from the latest tick.
  logic        s_valid;
  logic [15:0] s_instr;
  logic        s_req;
  logic [15:0] last_pop_pc;
  logic [15:0] last_pop_pc2;
  logic [15:0] last_acc_addr;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  // One clock cycle: drive memory side, check outputs, advance the model.
  task automatic tick();
    logic [15:0] exp_i;
    if (pend_v && pend_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = rd(pend_addr);
      pend_v      = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
      if (pend_v) pend_cnt--;
    end
    #1;
    imem_ack = imem_req && ($urandom_range(0, 99) < ack_pct);
    #1;
    s_valid = instr_valid;
    s_instr = instr;
    s_req   = imem_req;
    if (imem_req) begin
      checks++;
      if (redirect || m_stop || pend_v || imem_addr !== m_req_pc) begin
        errors++;
        $display("FAIL req_check: addr=%h redirect=%0b stop=%0b outstanding=%0b, required addr=%h and no blocking condition",
                 imem_addr, redirect, m_stop, pend_v, m_req_pc);
      end
    end
    if (instr_valid) begin
      exp_i = rd(m_pc);
      checks++;
      if (m_done || instr !== exp_i || instr_pc_plus2 !== m_pc + 16'd2) begin
        errors++;
        $display("FAIL deliver: instr=%h pc_plus2=%h after_hlt=%0b, required instr=%h pc_plus2=%h",
                 instr, instr_pc_plus2, m_done, exp_i, m_pc + 16'd2);
      end
      if (id_ready) begin
        last_pop_pc  = m_pc;
        last_pop_pc2 = instr_pc_plus2;
        if (exp_i[15:12] == 4'hF) m_done = 1'b1;
        m_pc = m_pc + 16'd2;
        n_deliv++;
      end
    end else begin
      checks++;
      if (instr !== 16'h0 || instr_pc_plus2 !== 16'h0) begin
        errors++;
        $display("FAIL idle_zero: instr=%h pc_plus2=%h, required 0000 0000", instr, instr_pc_plus2);
      end
    end
    if (imem_req && imem_ack) begin
      pend_v        = 1'b1;
      pend_cnt      = int'($urandom_range(lat_min, lat_max)) - 1;
      pend_addr     = imem_addr;
      last_acc_addr = imem_addr;
      exp_i         = rd(imem_addr);
      if (exp_i[15:12] == 4'hF) m_stop = 1'b1;
      m_req_pc = m_req_pc + 16'd2;
      n_acc++;
    end
    if (redirect) begin
      m_pc     = redirect_pc;
      m_req_pc = redirect_pc;
      m_stop   = 1'b0;
      m_done   = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic tick_redir(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic quiesce();
    ack_pct  = 0;
    id_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic set_mem(int pct, int lmin, int lmax);
    ack_pct = pct;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_req, instr_valid, fetch_halted} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: req/valid/halted=%b, required 000", {imem_req, instr_valid, fetch_halted});
    end
    checks++;
    if ({imem_addr, pc_out, instr, instr_pc_plus2} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h pc_out=%h instr=%h pc2=%h, required all 0000",
               imem_addr, pc_out, instr, instr_pc_plus2);
    end
    rst_n = 1'b1;
    m_pc = 16'h0; m_req_pc = 16'h0; m_stop = 1'b0; m_done = 1'b0;
    pend_v = 1'b0; pend_cnt = 0;
  endtask

  task automatic test_sequential();
    set_mem(100, 1, 1);
    id_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (n_deliv < 3) begin
      errors++;
      $display("FAIL seq_count: delivered=%0d, required >= 3", n_deliv);
    end
  endtask

  task automatic test_queue_full();
    int n0;
    int d0;
    quiesce();
    id_ready = 1'b0;
    tick_redir(16'h0000);
    set_mem(100, 1, 1);
    n0 = n_acc;
    repeat (20) tick();
    checks++;
    if (n_acc - n0 != 4) begin
      errors++;
      $display("FAIL full_accepts: accepted=%0d, required 4", n_acc - n0);
    end
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_stall: req=%b valid=%b, required req=0 valid=1", s_req, s_valid);
    end
    id_ready = 1'b1;
    d0 = n_deliv;
    repeat (20) tick();
    checks++;
    if (n_deliv - d0 < 6) begin
      errors++;
      $display("FAIL full_resume: delivered=%0d, required >= 6", n_deliv - d0);
    end
  endtask

  task automatic test_redirect_drain();
    quiesce();
    tick_redir(16'h0010);
    set_mem(100, 4, 4);
    tick();
    checks++;
    if (last_acc_addr !== 16'h0010) begin
      errors++;
      $display("FAIL drain_setup: accepted addr=%h, required 0010", last_acc_addr);
    end
    set_mem(100, 1, 1);
    tick_redir(16'h0040);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_req !== 1'b0 || s_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_quiet[%0d]: req=%b valid=%b, required 0 0", i, s_req, s_valid);
      end
    end
    tick();
    checks++;
    if (last_acc_addr !== 16'h0040) begin
      errors++;
      $display("FAIL drain_refetch: accepted addr=%h, required 0040", last_acc_addr);
    end
    repeat (6) tick();
  endtask

  task automatic test_halt();
    int n0;
    mem[4] = 16'hF000;
    quiesce();
    set_mem(100, 1, 1);
    tick_redir(16'h0000);
    for (int i = 0; i < 40 && !m_done; i++) tick();
    checks++;
    if (!m_done || last_pop_pc2 !== 16'h000A || fetch_halted !== 1'b1) begin
      errors++;
      $display("FAIL hlt_deliver: seen=%0b pc_plus2=%h halted=%b, required 1 000a 1",
               m_done, last_pop_pc2, fetch_halted);
    end
    n0 = n_acc;
    repeat (10) tick();
    checks++;
    if (n_acc != n0) begin
      errors++;
      $display("FAIL hlt_noreq: extra accepts=%0d, required 0", n_acc - n0);
    end
    tick_redir(16'h0020);
    checks++;
    if (fetch_halted !== 1'b0) begin
      errors++;
      $display("FAIL hlt_resume: halted=%b, required 0", fetch_halted);
    end
    repeat (6) tick();
    checks++;
    if (n_acc == n0) begin
      errors++;
      $display("FAIL hlt_refetch: no request after redirect, required fetch at 0020");
    end
    mem[4] = {4'($urandom_range(0, 14)), 12'($urandom)};
  endtask

  task automatic test_wrap();
    int d0;
    quiesce();
    set_mem(100, 1, 1);
    tick_redir(16'hFFFE);
    d0 = n_deliv;
    for (int i = 0; i < 20 && n_deliv == d0; i++) tick();
    checks++;
    if (last_pop_pc !== 16'hFFFE || last_pop_pc2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: pc=%h pc_plus2=%h, required fffe 0000", last_pop_pc, last_pop_pc2);
    end
    repeat (4) tick();
    checks++;
    if (m_req_pc[15:8] !== 8'h00) begin
      errors++;
      $display("FAIL wrap_req: next request pc=%h, required wrapped into 00xx", m_req_pc);
    end
  endtask

  task automatic test_latency();
    logic [15:0] exp_w;
    quiesce();
    set_mem(100, 1, 1);
    exp_w = rd(16'h0100);
    tick_redir(16'h0100);
    tick();
    tick();
`ifdef FETCH_BYPASS_EN
    checks++;
    if (s_valid !== 1'b1 || s_instr !== exp_w) begin
      errors++;
      $display("FAIL bypass_same: valid=%b instr=%h, required 1 %h", s_valid, s_instr, exp_w);
    end
`else
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_same: valid=%b, required 0", s_valid);
    end
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_instr !== exp_w) begin
      errors++;
      $display("FAIL lat_next: valid=%b instr=%h, required 1 %h", s_valid, s_instr, exp_w);
    end
`endif
  endtask

  task automatic test_random();
    int d0;
    set_mem(60, 1, 3);
    d0 = n_deliv;
    for (int i = 0; i < 1500; i++) begin
      id_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 4) tick_redir(16'($urandom) & 16'hFFFE);
      else tick();
    end
    checks++;
    if (n_deliv - d0 < 100) begin
      errors++;
      $display("FAIL random_progress: delivered=%0d, required >= 100", n_deliv - d0);
    end
    quiesce();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    n_deliv = 0; n_acc = 0;
    lat_min = 1; lat_max = 1; ack_pct = 0;
    last_pop_pc = '0; last_pop_pc2 = '0; last_acc_addr = '0;
    test_reset();
    test_sequential();
    test_queue_full();
    test_redirect_drain();
    test_halt();
    test_wrap();
    test_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised next-generation instruction fetch stage for the pipelined CPU.
- Replaces the single-cycle instruction memory plus PC register with a fetch engine that tolerates variable-latency instruction memory through a req/ack/rvalid handshake.
- Buffers fetched instructions in a DEPTH-entry prefetch queue that feeds IF/ID.
- Handles branch redirect (flush plus discard of any in-flight response) and stops fetching after HLT.

Parameters:
- DATA_W, 16, instruction width in bits.
- ADDR_W, 16, byte-address width of the PC.
- DEPTH, 4, prefetch queue entries; power of 2, at least 2.
- RESET_PC, 0, fetch PC after reset.
- HLT_OPCODE, 4'hF, value of instr[DATA_W-1:DATA_W-4] that stops fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; always equals fetch_pc.
- imem_ack  in  1  memory accepts the request this cycle (meaningful only when imem_req=1).
- imem_rvalid  in  1  response valid; exactly one response per accepted request.
- imem_rdata  in  DATA_W  response instruction.
- redirect  in  1  taken branch or jump from ID; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch PC.
- id_ready  in  1  IF/ID can accept (0 = stall).
- instr_valid  out  1  head of queue is valid.
- instr  out  DATA_W  head instruction; 0 when instr_valid=0.
- instr_pc_plus2  out  ADDR_W  PC of head instruction + 2; 0 when instr_valid=0.
- pc_out  out  ADDR_W  current fetch_pc.
- fetch_halted  out  1  FSM in HALTED.

Behaviour:
- Reset:
  - State FETCH, fetch_pc=RESET_PC, queue empty, nothing outstanding.
  - All outputs 0 except imem_addr/pc_out=RESET_PC.
- FSM states: FETCH, WAIT, DRAIN, HALTED. At most one outstanding request.
- FETCH:
  - imem_req=1 iff queue count < DEPTH.
  - On imem_req&imem_ack: latch req_pc=fetch_pc, fetch_pc<=fetch_pc+2 (mod 2^ADDR_W), go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: push {imem_rdata, req_pc+2}.
  - If the opcode field equals HLT_OPCODE, go to HALTED; else go to FETCH.
  - The next request can issue no earlier than the following cycle.
- DRAIN:
  - imem_req=0.
  - On imem_rvalid: discard the data, go to FETCH.
- HALTED:
  - imem_req=0; leave only on redirect.
  - The HLT instruction itself is still delivered from the queue.
- redirect has top priority in every state:
  - Queue flushed, fetch_pc<=redirect_pc.
  - Any request presented in the redirect cycle is suppressed (imem_req forced 0).
  - From WAIT without rvalid: go to DRAIN.
  - From WAIT with rvalid the same cycle: discard the response, go to FETCH.
  - Redirect in DRAIN: stay in DRAIN, take the new PC.
  - Redirect in HALTED or FETCH: go to FETCH.
  - A pop in the redirect cycle is allowed; the same-cycle flush wins for all remaining entries.
- Queue:
  - Pop on instr_valid&id_ready.
  - A request issues only when count<DEPTH, so the single reserved slot guarantees no overflow.
  - Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency without BYPASS_EN: rvalid in cycle N gives instr_valid in cycle N+1.
- Asynchronous reset mid-WAIT: state returns to reset values; a late rvalid arriving while in FETCH is ignored.
- imem_rvalid arriving in FETCH or HALTED is ignored.

Optional Feature:
- FETCH_BYPASS_EN.
- Defined:
  - When the queue is empty, state is WAIT, imem_rvalid=1 and id_ready=1, the response drives instr/instr_valid combinationally in the same cycle and is not pushed.
  - A HLT instruction still takes the FSM to HALTED.
  - Redirect suppresses the bypass.
- Undefined: every response goes through the queue (one-cycle latency).

Decomposition:
- Package fetch_pkg: fetch_state_t enum (FETCH, WAIT, DRAIN, HALTED), HLT_OPCODE default, opcode field position constants.
- Sub-module fetch_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports push, pop, flush, full, empty, count, din, dout.
  - Used for the {instr, pc_plus2} queue.

Test Plan:
- Reset with RESET_PC=0; memory acks immediately, 1-cycle rvalid, id_ready=1 → requests at 0,2,4; instrs emerge in order with pc_plus2=2,4,6.
- id_ready held 0, DEPTH=4 → exactly 4 responses queued; imem_req stays 0 with count=4; releasing id_ready resumes fetch and delivers addresses 0..6 in order.
- Redirect to 16'h0040 while WAIT with rvalid 3 cycles later → FSM enters DRAIN; the stale response is dropped; next request addr=0x0040; queue empty after redirect.
- Fetch of 16'hF000 at addr 8 → instruction delivered with pc_plus2=10; fetch_halted=1; no further imem_req; redirect to 0x20 resumes fetch at 0x20.
- fetch_pc=16'hFFFE → next request addr wraps to 0x0000; pc_plus2 of that instruction equals 0x0000.
- Bypass: FETCH_BYPASS_EN on, empty queue, rvalid with 16'h1234 → instr_valid=1 and instr=16'h1234 in the same cycle. With the macro off, the same stimulus gives instr_valid=1 in the next cycle.
